// File: rtl/piece_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | piece_pkg: shared types, constants and helpers for piece_selector |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package piece_pkg;

    localparam int pattern_addr_width_c = 5;

    typedef enum logic [2:0] {
        PIECE_NONE = 3'd0,
        PIECE_I    = 3'd1,
        PIECE_O    = 3'd2,
        PIECE_T    = 3'd3,
        PIECE_S    = 3'd4,
        PIECE_Z    = 3'd5,
        PIECE_J    = 3'd6,
        PIECE_L    = 3'd7
    } piece_e;

    typedef logic [1:0] rot_t;

    typedef enum logic [0:0] {
        GEN_FILL = 1'b0,
        GEN_HOLD = 1'b1
    } gen_state_e;

    typedef enum logic [1:0] {
        PS_IDLE   = 2'd0,
        PS_ACTIVE = 2'd1,
        PS_TRIAL  = 2'd2
    } piece_state_e;

    // Right-shifting Galois tap masks for maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0007_2000;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_B400;
        endcase
        return taps;
    endfunction

    // Lowest-numbered piece whose used bit is clear (bit 0 = piece 1).
    function automatic logic [2:0] lowest_free(input logic [6:0] used);
        logic [2:0] res;
        res = 3'd1;
        for (int i = 6; i >= 0; i--) begin
            if (!used[i]) res = 3'(i + 1);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_lfsr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | piece_lfsr: Galois LFSR with advance enable, exposes low 3 bits   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module piece_lfsr
    import piece_pkg::*;
#(
    parameter int                      lfsr_width_p = 16,
    parameter logic [lfsr_width_p-1:0] seed_p       = lfsr_width_p'(16'hACE1)
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       advance_i,
    output logic [2:0] draw_o
);

    localparam logic [lfsr_width_p-1:0] taps_c = lfsr_width_p'(lfsr_taps(lfsr_width_p));

    logic [lfsr_width_p-1:0] state;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= seed_p;
        end else if (advance_i) begin
            state <= state[0] ? ((state >> 1) ^ taps_c) : (state >> 1);
        end
    end

    assign draw_o = state[2:0];

endmodule
`default_nettype wire

// File: rtl/piece_selector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | piece_selector: next-piece generator, spawn and trial rotation    |
// | for the pattern ROM. PIECE_SELECT_BAG_EN enables 7-bag draws.     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module piece_selector
    import piece_pkg::*;
#(
    parameter int                      lfsr_width_p = 16,
    parameter logic [lfsr_width_p-1:0] seed_p       = lfsr_width_p'(16'hACE1)
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            spawn_v_i,
    output logic                            spawn_ready_o,
    input  logic                            rot_v_i,
    input  logic                            rot_dir_i,
    output logic                            rot_ready_o,
    input  logic                            verdict_v_i,
    input  logic                            verdict_ok_i,
    input  logic                            clear_i,
    output logic [pattern_addr_width_c-1:0] pattern_addr_o,
    output logic                            trial_o,
    output logic [pattern_addr_width_c-1:0] preview_addr_o,
    output logic                            next_v_o
);

    gen_state_e   gen_state;
    piece_state_e state;
    piece_e       next_piece;
    piece_e       cur_piece;
    rot_t         cur_rot;
    rot_t         trial_rot;
    logic         next_v;
    logic [2:0]   reject_cnt;
    logic [2:0]   cand;
    logic         cand_ok;
    logic [2:0]   pick;
    logic         take;
    logic         spawn_acc;

    piece_lfsr #(
        .lfsr_width_p (lfsr_width_p),
        .seed_p       (seed_p)
    ) u_lfsr (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .advance_i (gen_state == GEN_FILL),
        .draw_o    (cand)
    );

`ifdef PIECE_SELECT_BAG_EN
    logic [6:0] used;
    logic [6:0] cand_bit;
    logic [6:0] used_next;

    assign cand_bit  = (cand == 3'd0) ? 7'd0 : (7'd1 << (cand - 3'd1));
    assign cand_ok   = (cand != 3'd0) && ((cand_bit & used) == 7'd0);
    assign pick      = cand_ok ? cand : lowest_free(used);
    assign used_next = used | (7'd1 << (pick - 3'd1));

    // The bag empties on the same edge that takes its last piece.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            used <= 7'd0;
        end else if ((gen_state == GEN_FILL) && take) begin
            used <= (used_next == 7'h7F) ? 7'd0 : used_next;
        end
    end
`else
    assign cand_ok = (cand != 3'd0);
    assign pick    = cand_ok ? cand : 3'd1;
`endif

    assign take      = cand_ok || (reject_cnt == 3'd7);
    assign spawn_acc = spawn_v_i && spawn_ready_o && !clear_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gen_state  <= GEN_FILL;
            reject_cnt <= 3'd0;
            next_v     <= 1'b0;
            next_piece <= PIECE_NONE;
        end else if (gen_state == GEN_FILL) begin
            if (take) begin
                next_piece <= piece_e'(pick);
                next_v     <= 1'b1;
                reject_cnt <= 3'd0;
                gen_state  <= GEN_HOLD;
            end else begin
                reject_cnt <= reject_cnt + 3'd1;
            end
        end else if (spawn_acc) begin
            next_v    <= 1'b0;
            gen_state <= GEN_FILL;
        end
    end

    // Priority: clear, then spawn, then rotate, then verdict.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= PS_IDLE;
            cur_piece <= PIECE_NONE;
            cur_rot   <= 2'd0;
            trial_rot <= 2'd0;
        end else if (clear_i) begin
            state     <= PS_IDLE;
            cur_piece <= PIECE_NONE;
            cur_rot   <= 2'd0;
        end else if (spawn_acc) begin
            state     <= PS_ACTIVE;
            cur_piece <= next_piece;
            cur_rot   <= 2'd0;
        end else if (rot_v_i && rot_ready_o) begin
            state     <= PS_TRIAL;
            trial_rot <= rot_dir_i ? (cur_rot - 2'd1) : (cur_rot + 2'd1);
        end else if ((state == PS_TRIAL) && verdict_v_i) begin
            state <= PS_ACTIVE;
            if (verdict_ok_i) cur_rot <= trial_rot;
        end
    end

    assign spawn_ready_o  = next_v && (state != PS_TRIAL);
    assign rot_ready_o    = (state == PS_ACTIVE);
    assign trial_o        = (state == PS_TRIAL);
    assign next_v_o       = next_v;
    assign pattern_addr_o = {cur_piece, (state == PS_TRIAL) ? trial_rot : cur_rot};
    assign preview_addr_o = next_v ? {next_piece, 2'b00} : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_piece_selector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_piece_selector: vector table, random stimulus vs cycle model   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_piece_selector;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;
    localparam int IDLE = 0, ACTIVE = 1, TRIAL = 2;
`ifdef PIECE_SELECT_BAG_EN
    localparam bit BAG = 1'b1;
`else
    localparam bit BAG = 1'b0;
`endif

    typedef struct {
        bit         sp, rt, dir, vv, vok, clr;
        logic [1:0] rot;
        bit         trial, rrdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n_i, spawn_v_i, rot_v_i, rot_dir_i, verdict_v_i, verdict_ok_i, clear_i;
    logic       spawn_ready_o, rot_ready_o, trial_o, next_v_o;
    logic [4:0] pattern_addr_o, preview_addr_o;
    logic [13:0] dut_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    piece_selector dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n_i),
        .spawn_v_i      (spawn_v_i),
        .spawn_ready_o  (spawn_ready_o),
        .rot_v_i        (rot_v_i),
        .rot_dir_i      (rot_dir_i),
        .rot_ready_o    (rot_ready_o),
        .verdict_v_i    (verdict_v_i),
        .verdict_ok_i   (verdict_ok_i),
        .clear_i        (clear_i),
        .pattern_addr_o (pattern_addr_o),
        .trial_o        (trial_o),
        .preview_addr_o (preview_addr_o),
        .next_v_o       (next_v_o)
    );

    assign dut_out = {pattern_addr_o, trial_o, preview_addr_o, next_v_o, spawn_ready_o, rot_ready_o};

    // Behavioural model state
    int m_lfsr, m_rejects, m_next, m_mode, m_cur, m_rot, m_trial;
    bit m_nv;
    bit m_used[1:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_lfsr = 'hACE1; m_rejects = 0; m_next = 0; m_nv = 0;
        m_mode = IDLE; m_cur = 0; m_rot = 0; m_trial = 0;
        for (int p = 1; p <= 7; p++) m_used[p] = 0;
    endtask

    task automatic model_clock(input bit sp, rt, dir, vv, vok, clr);
        bit taken;
        taken = sp && m_nv && (m_mode != TRIAL) && !clr;
        if (!m_nv) begin
            int  c;
            bit  ok;
            bit  full;
            c  = m_lfsr % 8;
            ok = (c != 0) && !(BAG && m_used[c]);
            if (!ok && m_rejects == 7) begin
                for (int p = 7; p >= 1; p--) if (!m_used[p]) c = p;
                ok = 1;
            end
            if (ok) begin
                m_next = c; m_nv = 1; m_rejects = 0;
                if (BAG) begin
                    m_used[c] = 1;
                    full = 1;
                    for (int p = 1; p <= 7; p++) if (!m_used[p]) full = 0;
                    if (full) for (int p = 1; p <= 7; p++) m_used[p] = 0;
                end
            end else begin
                m_rejects++;
            end
            m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
        end else if (taken) begin
            m_nv = 0;
        end
        if (clr) begin
            m_mode = IDLE; m_cur = 0; m_rot = 0;
        end else if (taken) begin
            m_mode = ACTIVE; m_cur = m_next; m_rot = 0;
        end else if (m_mode == ACTIVE && rt) begin
            m_mode = TRIAL; m_trial = (m_rot + (dir ? 3 : 1)) % 4;
        end else if (m_mode == TRIAL && vv) begin
            m_mode = ACTIVE;
            if (vok) m_rot = m_trial;
        end
    endtask

    function automatic logic [13:0] model_out();
        logic [4:0] addr, prev;
        addr = 5'(m_cur * 4 + ((m_mode == TRIAL) ? m_trial : m_rot));
        prev = m_nv ? 5'(m_next * 4) : 5'd0;
        return {addr, (m_mode == TRIAL), prev, m_nv, (m_nv && m_mode != TRIAL), (m_mode == ACTIVE)};
    endfunction

    task automatic cycle(input bit sp, rt, dir, vv, vok, clr, input string name);
        spawn_v_i = sp; rot_v_i = rt; rot_dir_i = dir;
        verdict_v_i = vv; verdict_ok_i = vok; clear_i = clr;
        @(posedge clk);
        model_clock(sp, rt, dir, vv, vok, clr);
        #1;
        check(name, 32'(dut_out), 32'(model_out()));
    endtask

    function automatic vec_t v(input bit sp, rt, dir, vv, vok, clr,
                               input logic [1:0] rot, input bit trial, rrdy);
        vec_t r;
        r.sp = sp; r.rt = rt; r.dir = dir; r.vv = vv; r.vok = vok; r.clr = clr;
        r.rot = rot; r.trial = trial; r.rrdy = rrdy;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[28];
        int   waited;
        bit   rdy;
        int   pieces[$];
        logic [6:0] mask;
        int   bad;

        //          sp rt dir vv vok clr  rot   trial rrdy
        vecs[0]  = v(T, F, F, F, F, F, 2'd0, F, T);
        vecs[1]  = v(F, T, F, F, F, F, 2'd1, T, F);
        vecs[2]  = v(F, F, F, T, T, F, 2'd1, F, T);
        vecs[3]  = v(F, T, F, F, F, F, 2'd2, T, F);
        vecs[4]  = v(F, F, F, T, T, F, 2'd2, F, T);
        vecs[5]  = v(F, T, F, F, F, F, 2'd3, T, F);
        vecs[6]  = v(F, F, F, T, T, F, 2'd3, F, T);
        vecs[7]  = v(F, T, F, F, F, F, 2'd0, T, F);
        vecs[8]  = v(F, F, F, T, T, F, 2'd0, F, T);
        vecs[9]  = v(F, T, T, F, F, F, 2'd3, T, F);
        vecs[10] = v(F, F, F, T, F, F, 2'd0, F, T);
        vecs[11] = v(F, T, F, F, F, F, 2'd1, T, F);
        vecs[12] = v(T, F, F, F, F, F, 2'd1, T, F);
        vecs[13] = v(F, F, F, T, F, F, 2'd0, F, T);
        vecs[14] = v(T, T, F, T, T, T, 2'd0, F, F);
        vecs[15] = v(F, F, F, T, T, F, 2'd0, F, F);
        vecs[16] = v(T, T, F, F, F, F, 2'd0, F, T);
        for (int i = 17; i <= 24; i++) vecs[i] = v(F, F, F, F, F, F, 2'd0, F, T);
        vecs[25] = v(T, T, F, F, F, F, 2'd0, F, T);
        vecs[26] = v(F, T, F, F, F, F, 2'd1, T, F);
        vecs[27] = v(F, F, F, T, T, T, 2'd0, F, F);

        rst_n_i = 1'b0; spawn_v_i = 1'b0; rot_v_i = 1'b0; rot_dir_i = 1'b0;
        verdict_v_i = 1'b0; verdict_ok_i = 1'b0; clear_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(dut_out), 32'd0);
        rst_n_i = 1'b1;
        #1;
        check("first_cycle_outputs", 32'(dut_out), 32'd0);

        waited = 0;
        while (!next_v_o && waited < 12) begin
            cycle(F, F, F, F, F, F, "fill_wait");
            waited++;
        end
        check("first_next_v_latency_in_1_to_8", 32'(waited >= 1 && waited <= 8), 32'd1);
        check("preview_rot_bits_zero", 32'(preview_addr_o[1:0]), 32'd0);
        check("preview_piece_nonzero", 32'(preview_addr_o[4:2] != 3'd0), 32'd1);

        foreach (vecs[i]) begin
            cycle(vecs[i].sp, vecs[i].rt, vecs[i].dir, vecs[i].vv, vecs[i].vok, vecs[i].clr,
                  $sformatf("vec%0d_model", i));
            check($sformatf("vec%0d_rot_trial_rdy", i),
                  32'({pattern_addr_o[1:0], trial_o, rot_ready_o}),
                  32'({vecs[i].rot, vecs[i].trial, vecs[i].rrdy}));
        end

        repeat (1500) begin
            cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
                  "random");
        end

        #3 rst_n_i = 1'b0;
        #1;
        check("async_reset_midrun", 32'(dut_out), 32'd0);
        model_reset();
        spawn_v_i = 1'b0; rot_v_i = 1'b0; verdict_v_i = 1'b0; clear_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n_i = 1'b1;

        waited = 0;
        while (pieces.size() < 70 && waited < 1000) begin
            rdy = spawn_ready_o;
            cycle(T, F, F, F, F, F, "spawn_stream");
            if (rdy) pieces.push_back(int'(pattern_addr_o[4:2]));
            waited++;
        end
        check("spawn_stream_count", 32'(pieces.size()), 32'd70);

        bad = 0;
        mask = 7'd0;
        foreach (pieces[i]) begin
            if (pieces[i] < 1 || pieces[i] > 7) bad++;
            else mask = mask | (7'd1 << (pieces[i] - 1));
        end
        check("pieces_in_1_to_7", 32'(bad), 32'd0);
`ifdef PIECE_SELECT_BAG_EN
        for (int g = 0; g < pieces.size() / 7; g++) begin
            logic [6:0] gm;
            gm = 7'd0;
            for (int k = 0; k < 7; k++) begin
                if (pieces[g * 7 + k] >= 1 && pieces[g * 7 + k] <= 7)
                    gm = gm | (7'd1 << (pieces[g * 7 + k] - 1));
            end
            check($sformatf("bag_group%0d_permutation", g), 32'(gm), 32'h7F);
        end
`else
        check("all_pieces_seen_in_70", 32'(mask), 32'h7F);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piece_selector.md
# piece_selector

- Generates the address stream for the 32-entry piece pattern ROM: `{piece[2:0], rot[1:0]}`, where piece 0 is the empty pattern.
- Draws upcoming pieces from an LFSR into a one-deep next-piece slot, spawns them on request and tracks rotation of the active piece.
- Rotation uses a trial/verdict handshake, so downstream collision logic can accept or reject a candidate rotation before it is committed.
- Sits directly upstream of the pattern ROM and between the game controller and the ROM.

## Interface
- `lfsr_width_p`, default 16: LFSR width, minimum 8.
- `seed_p`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk_i`  in  1: sole clock.
- `rst_n_i`  in  1: reset, asynchronous assert, active-low.
- `spawn_v_i`  in  1: request to make the next piece active.
- `spawn_ready_o`  out  1: spawn is accepted when `spawn_v_i & spawn_ready_o`.
- `rot_v_i`  in  1: rotate request.
- `rot_dir_i`  in  1: rotation direction, 0 = cw (+1), 1 = ccw (−1), mod 4.
- `rot_ready_o`  out  1: rotate is accepted when `rot_v_i & rot_ready_o`.
- `verdict_v_i`  in  1: downstream verdict on the trial rotation is valid.
- `verdict_ok_i`  in  1: 1 = commit the trial rotation, 0 = discard it.
- `clear_i`  in  1: drop the active piece (lock or game over).
- `pattern_addr_o`  out  5: ROM address for the active piece, or the trial rotation.
- `trial_o`  out  1: `pattern_addr_o` currently carries a trial rotation.
- `preview_addr_o`  out  5: `{next_piece, 2'b00}` when the next slot is valid, else 0.
- `next_v_o`  out  1: next-piece slot is valid.

## Operation

**Generator FSM {FILL, HOLD}**
- In FILL, the LFSR advances one step per cycle; the candidate is `lfsr[2:0]`.
- The candidate is accepted if it is in 1..7 and, with the bag feature enabled, not yet used.
- After 7 rejected cycles, the 8th cycle forces the lowest-numbered eligible piece.
- On acceptance: load the next slot, set `next_v_o`, go to HOLD.
- In HOLD, the LFSR is frozen; an accepted spawn returns the FSM to FILL.
- LFSR: Galois form, taps for maximal length at `lfsr_width_p` (16: 0xB400).

**Piece FSM {IDLE, ACTIVE, TRIAL}**
- IDLE: current piece = 0, so `pattern_addr_o` = 0..3 (empty rows).
- Spawn: `spawn_ready_o = next_v & (state != TRIAL)`. Accepted from IDLE or ACTIVE: cur_piece ← next, cur_rot ← 0, go to ACTIVE, clear `next_v`.
- Rotate: `rot_ready_o = (state == ACTIVE)`. Accepted: trial_rot ← cur_rot ± 1 (2-bit wrap: 3 + 1 = 0, 0 − 1 = 3), go to TRIAL, `trial_o` = 1.
- In TRIAL, `pattern_addr_o = {cur_piece, trial_rot}`.
- Verdict in TRIAL: ok → cur_rot ← trial_rot; not ok → cur_rot unchanged. Either way return to ACTIVE.
- `verdict_v_i` outside TRIAL is ignored.
- `clear_i` forces IDLE from any state, discarding any trial. The next slot and generator are unaffected.

**Simultaneous events** (priority order)
- `clear_i` beats spawn, rotate and verdict.
- Spawn beats rotate in the same cycle.
- Spawn in the cycle the generator completes FILL is not accepted, because `next_v` is not yet visible.

## Timing
- Reset values: `pattern_addr_o` = 0, `preview_addr_o` = 0, `next_v_o` = 0, `trial_o` = 0, `spawn_ready_o` = 0, `rot_ready_o` = 0. LFSR = `seed_p`, generator in FILL, piece FSM in IDLE.
- All outputs are registered, or decoded from registered state only. Latency from an accepted event to its visible effect is 1 cycle.
- First `next_v_o` rise occurs 1–8 cycles after reset release.
- After a spawn, `next_v_o` falls the next cycle and re-rises 1–8 cycles later.
- Reset asserted mid-operation returns everything immediately to the reset values.

## Configuration
- **`PIECE_SELECT_BAG_EN`** defined: 7-bag randomizer.
  - A 7-bit used mask marks each accepted piece.
  - Used pieces are ineligible in FILL.
  - The mask clears in the same cycle the 7th piece is accepted.
  - Every run of 7 consecutive draws starting at a bag boundary contains each piece exactly once.
  - The mask resets to 0.
- Undefined: plain LFSR draw with the zero-reject and forced-accept rule; no mask logic.

## Structure
- `piece_pkg` holds:
  - piece enum (NONE = 0, pieces 1..7);
  - 2-bit rotation type;
  - `pattern_addr_width_c` = 5;
  - both FSM state enums.
- Sub-module: `piece_lfsr`, a Galois LFSR with `lfsr_width_p`, `seed_p` and an `advance_i` enable.

## Test plan
- **Reset:** release reset → all outputs 0 on the first cycle; `next_v_o` = 1 within 8 cycles; `preview_addr_o[1:0]` = 0 and `preview_addr_o[4:2]` ≠ 0.
- **Spawn:** spawn with next = 3 → the next cycle `pattern_addr_o` = 12, `next_v_o` = 0, FSM in ACTIVE.
- **Rotate commit and wrap:**
  - Active piece 3, rot 3: rotate cw → `pattern_addr_o` = 12 with `trial_o` = 1.
  - Verdict ok → `pattern_addr_o` = 12 with `trial_o` = 0.
  - Rotate ccw from rot 0 → trial address 15.
- **Rotate reject:** active piece 5, rot 1: rotate cw → trial address 22. Verdict not ok → address returns to 21; spawn during TRIAL gets `spawn_ready_o` = 0.
- **Priority:** `clear_i` with `verdict_v_i` and `spawn_v_i` in the same cycle → `pattern_addr_o` = 0, FSM in IDLE, next slot retained.
- **`PIECE_SELECT_BAG_EN`:** 70 consecutive spawns → each aligned group of 7 pieces is a permutation of 1..7. Without the macro: every piece is in 1..7, and each piece appears at least once within 70 draws.
